// File: rtl/id_ex_stage_pkg.sv
// Shared LEGv8 pipeline constants: zero register, control-bundle layout, ALU_OP encodings.
package id_ex_stage_pkg;

    localparam logic [4:0] XZR = 5'd31;

    // Control bundle: {ALU_OP[1:0], ALU_SRC, MEM_READ, MEM_WRITE, MEM_TO_REG, REG_WRITE, BRANCH, UNCOND_BRANCH}
    localparam int CTRL_W          = 9;
    localparam int CTRL_ALU_OP_HI  = 8;
    localparam int CTRL_ALU_OP_LO  = 7;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_UNCOND     = 0;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX.
// Latency: purely combinational. Backpressure: none; the caller decides how to stall.
// XZR is never a real destination, so a load into X31 never creates a dependency.
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic             id_uses_rn1,
    input  logic [REG_W-1:0] id_rn1,
    input  logic             id_uses_rm2,
    input  logic [REG_W-1:0] id_rm2,
    output logic             hazard
);

    logic rn1_hit;
    logic rm2_hit;
    logic ex_is_load;

    assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != REG_W'(XZR));
    assign rn1_hit    = id_uses_rn1 & (id_rn1 == ex_rd);
    assign rm2_hit    = id_uses_rm2 & (id_rm2 == ex_rd);
    assign hazard     = ex_is_load & id_valid & (rn1_hit | rm2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; optional bubble counter under HAZARD_PERF_CNT_EN.
// Latency: one cycle ID->EX. Backpressure: HOLD_IN freezes contents; STALL_OUT holds PC and IF/ID on load-use.
// Priority per edge: RESET > FLUSH_IN > HOLD_IN > hazard bubble > capture.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ID_VALID_IN,
    input  logic [DATA_W-1:0] ID_PC_IN,
    input  logic [DATA_W-1:0] ID_READ_DATA1_IN,
    input  logic [DATA_W-1:0] ID_READ_DATA2_IN,
    input  logic [DATA_W-1:0] ID_IMM_IN,
    input  logic [REG_W-1:0]  ID_RN1_IN,
    input  logic [REG_W-1:0]  ID_RM2_IN,
    input  logic [REG_W-1:0]  ID_RD_IN,
    input  logic              ID_USES_RN1_IN,
    input  logic              ID_USES_RM2_IN,
    input  logic [CTRL_W-1:0] ID_CTRL_IN,
    input  logic              FLUSH_IN,
    input  logic              HOLD_IN,
    output logic              EX_VALID_OUT,
    output logic [DATA_W-1:0] EX_PC_OUT,
    output logic [DATA_W-1:0] EX_READ_DATA1_OUT,
    output logic [DATA_W-1:0] EX_READ_DATA2_OUT,
    output logic [DATA_W-1:0] EX_IMM_OUT,
    output logic [REG_W-1:0]  EX_RN1_OUT,
    output logic [REG_W-1:0]  EX_RM2_OUT,
    output logic [REG_W-1:0]  EX_RD_OUT,
    output logic [CTRL_W-1:0] EX_CTRL_OUT,
    output logic              STALL_OUT,
    output logic [31:0]       BUBBLE_CNT_OUT
);

    localparam logic [REG_W-1:0] REG_XZR = REG_W'(XZR);

    logic hazard;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .ex_valid    (EX_VALID_OUT),
        .ex_mem_read (EX_CTRL_OUT[CTRL_MEM_READ]),
        .ex_rd       (EX_RD_OUT),
        .id_valid    (ID_VALID_IN),
        .id_uses_rn1 (ID_USES_RN1_IN),
        .id_rn1      (ID_RN1_IN),
        .id_uses_rm2 (ID_USES_RM2_IN),
        .id_rm2      (ID_RM2_IN),
        .hazard      (hazard)
    );

    // No HOLD_IN term: a held hazard keeps stalling until the bubble can actually be loaded.
    assign STALL_OUT = hazard & ~FLUSH_IN;

    always_ff @(posedge CLOCK) begin
        if (RESET || FLUSH_IN || (!HOLD_IN && hazard)) begin
            EX_VALID_OUT      <= 1'b0;
            EX_PC_OUT         <= '0;
            EX_READ_DATA1_OUT <= '0;
            EX_READ_DATA2_OUT <= '0;
            EX_IMM_OUT        <= '0;
            EX_RN1_OUT        <= REG_XZR;
            EX_RM2_OUT        <= REG_XZR;
            EX_RD_OUT         <= REG_XZR;
            EX_CTRL_OUT       <= CTRL_BUBBLE;
        end else if (!HOLD_IN) begin
            EX_VALID_OUT      <= ID_VALID_IN;
            EX_PC_OUT         <= ID_PC_IN;
            EX_READ_DATA1_OUT <= ID_READ_DATA1_IN;
            EX_READ_DATA2_OUT <= ID_READ_DATA2_IN;
            EX_IMM_OUT        <= ID_IMM_IN;
            EX_RN1_OUT        <= ID_RN1_IN;
            EX_RM2_OUT        <= ID_RM2_IN;
            // An invalid slot must never look like a writer to forwarding or hazard logic.
            EX_RD_OUT         <= ID_VALID_IN ? ID_RD_IN : REG_XZR;
            EX_CTRL_OUT       <= ID_VALID_IN ? ID_CTRL_IN : CTRL_BUBBLE;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] bubble_cnt;

    // Counts only load-use bubbles, not flush or reset bubbles.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            bubble_cnt <= '0;
        end else if (!FLUSH_IN && !HOLD_IN && hazard) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign BUBBLE_CNT_OUT = bubble_cnt;
`else
    assign BUBBLE_CNT_OUT = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, capture, load-use stall, XZR, flush/hold priority, counter.
module tb_id_ex_stage;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        ID_VALID_IN;
    logic [63:0] ID_PC_IN, ID_READ_DATA1_IN, ID_READ_DATA2_IN, ID_IMM_IN;
    logic [4:0]  ID_RN1_IN, ID_RM2_IN, ID_RD_IN;
    logic        ID_USES_RN1_IN, ID_USES_RM2_IN;
    logic [8:0]  ID_CTRL_IN;
    logic        FLUSH_IN, HOLD_IN;
    logic        EX_VALID_OUT;
    logic [63:0] EX_PC_OUT, EX_READ_DATA1_OUT, EX_READ_DATA2_OUT, EX_IMM_OUT;
    logic [4:0]  EX_RN1_OUT, EX_RM2_OUT, EX_RD_OUT;
    logic [8:0]  EX_CTRL_OUT;
    logic        STALL_OUT;
    logic [31:0] BUBBLE_CNT_OUT;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ADD: ALU_OP=10, REG_WRITE.  LDUR: ALU_SRC, MEM_READ, MEM_TO_REG, REG_WRITE.
    localparam logic [8:0] C_ADD  = 9'b10_0_0_0_0_1_0_0;
    localparam logic [8:0] C_LDUR = 9'b00_1_1_0_1_1_0_0;

    always #5 CLOCK = ~CLOCK;

    id_ex_stage dut (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .ID_VALID_IN       (ID_VALID_IN),
        .ID_PC_IN          (ID_PC_IN),
        .ID_READ_DATA1_IN  (ID_READ_DATA1_IN),
        .ID_READ_DATA2_IN  (ID_READ_DATA2_IN),
        .ID_IMM_IN         (ID_IMM_IN),
        .ID_RN1_IN         (ID_RN1_IN),
        .ID_RM2_IN         (ID_RM2_IN),
        .ID_RD_IN          (ID_RD_IN),
        .ID_USES_RN1_IN    (ID_USES_RN1_IN),
        .ID_USES_RM2_IN    (ID_USES_RM2_IN),
        .ID_CTRL_IN        (ID_CTRL_IN),
        .FLUSH_IN          (FLUSH_IN),
        .HOLD_IN           (HOLD_IN),
        .EX_VALID_OUT      (EX_VALID_OUT),
        .EX_PC_OUT         (EX_PC_OUT),
        .EX_READ_DATA1_OUT (EX_READ_DATA1_OUT),
        .EX_READ_DATA2_OUT (EX_READ_DATA2_OUT),
        .EX_IMM_OUT        (EX_IMM_OUT),
        .EX_RN1_OUT        (EX_RN1_OUT),
        .EX_RM2_OUT        (EX_RM2_OUT),
        .EX_RD_OUT         (EX_RD_OUT),
        .EX_CTRL_OUT       (EX_CTRL_OUT),
        .STALL_OUT         (STALL_OUT),
        .BUBBLE_CNT_OUT    (BUBBLE_CNT_OUT)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [63:0] pc, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] imm,
                          input logic [4:0] rn1, input logic [4:0] rm2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [8:0] ctrl);
        ID_VALID_IN      = v;
        ID_PC_IN         = pc;
        ID_READ_DATA1_IN = d1;
        ID_READ_DATA2_IN = d2;
        ID_IMM_IN        = imm;
        ID_RN1_IN        = rn1;
        ID_RM2_IN        = rm2;
        ID_RD_IN         = rd;
        ID_USES_RN1_IN   = u1;
        ID_USES_RM2_IN   = u2;
        ID_CTRL_IN       = ctrl;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 64'(EX_VALID_OUT), 64'd0);
        chk({tag, "_rd"},    64'(EX_RD_OUT),    64'd31);
        chk({tag, "_ctrl"},  64'(EX_CTRL_OUT),  64'd0);
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
        return CNT_EN ? 64'(n) : 64'd0;
    endfunction

    initial begin
        RESET = 1'b1; FLUSH_IN = 1'b0; HOLD_IN = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
        tick(); tick();
        chk_bubble("rst");
        chk("rst_rn1",   64'(EX_RN1_OUT), 64'd31);
        chk("rst_rm2",   64'(EX_RM2_OUT), 64'd31);
        chk("rst_pc",    EX_PC_OUT, 64'd0);
        chk("rst_stall", 64'(STALL_OUT), 64'd0);
        chk("rst_cnt",   64'(BUBBLE_CNT_OUT), 64'd0);

        // ADD X1, X2, X3
        RESET = 1'b0;
        set_id(1, 64'h100, 64'h11, 64'h22, 64'h0, 5'd2, 5'd3, 5'd1, 1, 1, C_ADD);
        tick();
        chk("add_valid", 64'(EX_VALID_OUT), 64'd1);
        chk("add_rd",    64'(EX_RD_OUT),  64'd1);
        chk("add_rn1",   64'(EX_RN1_OUT), 64'd2);
        chk("add_rm2",   64'(EX_RM2_OUT), 64'd3);
        chk("add_regwr", 64'(EX_CTRL_OUT[2]), 64'd1);
        chk("add_pc",    EX_PC_OUT, 64'h100);
        chk("add_d1",    EX_READ_DATA1_OUT, 64'h11);

        // LDUR X5,[X9,#8] then ADD X6,X5,X7
        set_id(1, 64'h104, 64'h900, 64'h0, 64'h8, 5'd9, 5'd0, 5'd5, 1, 0, C_LDUR);
        tick();
        chk("ld_ctrl", 64'(EX_CTRL_OUT), 64'(C_LDUR));
        chk("ld_imm",  EX_IMM_OUT, 64'h8);
        set_id(1, 64'h108, 64'h0, 64'h77, 64'h0, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
        #1;
        chk("lu_stall", 64'(STALL_OUT), 64'd1);
        tick();
        chk_bubble("lu_bub");
        chk("lu_stall_after", 64'(STALL_OUT), 64'd0);
        chk("lu_cnt1", 64'(BUBBLE_CNT_OUT), exp_cnt(1));
        tick();
        chk("lu_rn1", 64'(EX_RN1_OUT), 64'd5);
        chk("lu_rd",  64'(EX_RD_OUT),  64'd6);
        chk("lu_pc",  EX_PC_OUT, 64'h108);

        // LDUR XZR, then ID reading X31: no stall
        set_id(1, 64'h10c, 64'h0, 64'h0, 64'h0, 5'd9, 5'd0, 5'd31, 1, 0, C_LDUR);
        tick();
        set_id(1, 64'h110, 64'h0, 64'h0, 64'h0, 5'd31, 5'd0, 5'd4, 1, 0, C_LDUR);
        #1;
        chk("xzr_stall", 64'(STALL_OUT), 64'd0);
        tick();
        // EX now LDUR X4; ID has X4 only on an unused RM2
        set_id(1, 64'h114, 64'h0, 64'h0, 64'h0, 5'd8, 5'd4, 5'd10, 1, 0, C_ADD);
        #1;
        chk("unused_stall", 64'(STALL_OUT), 64'd0);
        tick();
        chk("unused_rm2",   64'(EX_RM2_OUT), 64'd4);
        chk("unused_valid", 64'(EX_VALID_OUT), 64'd1);

        // Invalid slot captured: RD and CTRL forced, other fields captured
        set_id(0, 64'h118, 64'h0, 64'h0, 64'h0, 5'd12, 5'd13, 5'd9, 1, 1, C_LDUR);
        tick();
        chk_bubble("inv");
        chk("inv_rn1", 64'(EX_RN1_OUT), 64'd12);

        // Flush beats hold and hazard
        set_id(1, 64'h120, 64'h0, 64'h0, 64'h0, 5'd9, 5'd0, 5'd5, 1, 0, C_LDUR);
        tick();
        set_id(1, 64'h124, 64'h0, 64'h0, 64'h0, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
        FLUSH_IN = 1'b1; HOLD_IN = 1'b1;
        #1;
        chk("fl_stall", 64'(STALL_OUT), 64'd0);
        tick();
        chk_bubble("fl_bub");
        chk("fl_cnt", 64'(BUBBLE_CNT_OUT), exp_cnt(1));
        FLUSH_IN = 1'b0; HOLD_IN = 1'b0;

        // Hold for three cycles during a hazard
        set_id(1, 64'h128, 64'h0, 64'h0, 64'h8, 5'd9, 5'd0, 5'd5, 1, 0, C_LDUR);
        tick();
        set_id(1, 64'h12c, 64'h0, 64'h0, 64'h0, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
        HOLD_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold_stall%0d", i), 64'(STALL_OUT), 64'd1);
            tick();
            chk($sformatf("hold_rd%0d", i),   64'(EX_RD_OUT), 64'd5);
            chk($sformatf("hold_pc%0d", i),   EX_PC_OUT, 64'h128);
            chk($sformatf("hold_ctrl%0d", i), 64'(EX_CTRL_OUT), 64'(C_LDUR));
            chk($sformatf("hold_cnt%0d", i),  64'(BUBBLE_CNT_OUT), exp_cnt(1));
        end
        HOLD_IN = 1'b0;
        #1;
        chk("hold_stall_rel", 64'(STALL_OUT), 64'd1);
        tick();
        chk_bubble("hold_bub");
        chk("hold_cnt2", 64'(BUBBLE_CNT_OUT), exp_cnt(2));
        tick();
        chk("hold_rn1", 64'(EX_RN1_OUT), 64'd5);

        // Reset in the middle of a stall
        set_id(1, 64'h130, 64'h0, 64'h0, 64'h0, 5'd9, 5'd0, 5'd5, 1, 0, C_LDUR);
        tick();
        set_id(1, 64'h134, 64'h0, 64'h0, 64'h0, 5'd7, 5'd5, 5'd6, 1, 1, C_ADD);
        #1;
        chk("rs_stall_rm2", 64'(STALL_OUT), 64'd1);
        RESET = 1'b1;
        tick();
        chk_bubble("rs_bub");
        chk("rs_stall", 64'(STALL_OUT), 64'd0);
        chk("rs_cnt",   64'(BUBBLE_CNT_OUT), 64'd0);
        RESET = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
